// File: rtl/lcds_pkg.sv
// Shared definitions for the keypad scanner.
//   KEY_RUN / KEY_MEM : key indices of the two keys on column 0
//   NUM_KEYS          : size of the debounced key-state vector
//   key_event_t       : one key event {is_release, code}
//   scan_state_t      : scan FSM states
package lcds_pkg;

    localparam int KEY_RUN  = 16;
    localparam int KEY_MEM  = 17;
    localparam int NUM_KEYS = 20;

    // "release" is a reserved word, so the release flag is named is_release.
    typedef struct packed {
        logic       is_release;
        logic [4:0] code;
    } key_event_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_EMIT
    } scan_state_t;

endpackage

// File: rtl/keypad_event_fifo.sv
// Key-event FIFO.
//   clk, reset_n : clock, async active-low reset (empties the FIFO)
//   push, din    : write request and event; dropped when full unless a pop
//                  happens in the same cycle
//   pop          : read request; ignored when empty
//   dout         : head event, zero when empty
//   full, empty  : occupancy flags
module keypad_event_fifo
    import lcds_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  key_event_t din,
    input  logic       pop,
    output key_event_t dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    key_event_t mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 5-column x 4-row keypad scanner with per-key debounce and event FIFO.
//   clk, reset_n      : clock, async active-low reset
//   enable            : scan enable; low parks the scanner in IDLE
//   row[3:0]          : row sense inputs, active high
//   col[4:0]          : one-hot column strobe, zero when idle
//   key_valid         : event FIFO not empty
//   key_code[4:0]     : head event key index
//   key_release       : head event is a release
//   key_ready         : consumer pops the head when key_valid is high
//   overflow          : sticky, an event was dropped; clear_ovf clears it
//   any_key           : OR of all debounced key states
module keypad_scanner
    import lcds_pkg::*;
#(
    parameter int DWELL      = 1000,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] row,
    output logic [4:0] col,
    output logic       key_valid,
    output logic [4:0] key_code,
    output logic       key_release,
    input  logic       key_ready,
    output logic       overflow,
    input  logic       clear_ovf,
    output logic       any_key
);
    scan_state_t              state;
    logic [15:0]              dwell_cnt;
    logic [2:0]               c;
    logic [1:0]               e;
    logic [3:0]               row_q;
    logic [NUM_KEYS-1:0]      stable;
    logic [NUM_KEYS-1:0][1:0] cnt;

    logic [2:0]  c_next;
    logic [4:0]  k;
    logic        key_active;
    logic        s;
    logic        flip;
    key_event_t  ev;
    key_event_t  head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        do_pop;
    logic        drop;

    assign c_next = (c == 3'd0) ? 3'd4 : c - 3'd1;

    // Column 0 only carries RUN (e=1) and MEM (e=2); the other rows there
    // are not wired to keys.
    always_comb begin
        k = {3'(3'd4 - c), e};
        if (c == 3'd0) k = 5'(KEY_RUN) + {3'b000, e} - 5'd1;
        key_active    = (state == ST_EMIT) && enable && !((c == 3'd0) && ((e == 2'd0) || (e == 2'd3)));
        s             = row_q[e];
        flip          = key_active && (s != stable[k]) && (({1'b0, cnt[k]} + 3'd1) == 3'(DEBOUNCE));
        ev.is_release = ~s;
        ev.code       = k;
    end

    // Scan sequencer: dwell on a column, then walk its four rows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            col       <= '0;
            c         <= 3'd4;
            e         <= '0;
            dwell_cnt <= '0;
            row_q     <= '0;
        end else if (!enable) begin
            state     <= ST_IDLE;
            col       <= '0;
            c         <= 3'd4;
            e         <= '0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_DWELL;
                    c         <= 3'd4;
                    col       <= 5'b10000;
                    dwell_cnt <= '0;
                end
                ST_DWELL: begin
                    if (dwell_cnt == 16'(DWELL - 1)) begin
                        row_q     <= row;
                        e         <= '0;
                        dwell_cnt <= '0;
                        state     <= ST_EMIT;
                    end else begin
                        dwell_cnt <= dwell_cnt + 16'd1;
                    end
                end
                ST_EMIT: begin
                    if (e == 2'd3) begin
                        c     <= c_next;
                        col   <= 5'd1 << c_next;
                        e     <= '0;
                        state <= ST_DWELL;
                    end else begin
                        e <= e + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Per-key debounce; the stable state flips even if the event is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable  <= '0;
            cnt     <= '0;
            any_key <= 1'b0;
        end else begin
            any_key <= |stable;
            if (key_active) begin
                if (s == stable[k]) begin
                    cnt[k] <= '0;
                end else if (flip) begin
                    stable[k] <= s;
                    cnt[k]    <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 2'd1;
                end
            end
        end
    end

    assign do_pop = key_ready & ~fifo_empty;
    assign drop   = flip & fifo_full & ~do_pop;

    // A drop in the same cycle as clear_ovf wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (clear_ovf) overflow <= 1'b0;
    end

    keypad_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (flip),
        .din     (ev),
        .pop     (key_ready),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign key_valid   = ~fifo_empty;
    assign key_code    = head.code;
    assign key_release = head.is_release;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with DWELL=4, DEBOUNCE=2, FIFO_DEPTH=4.
// The reference model tracks the scan by counting clock edges since the
// scan started and deriving column/row positions arithmetically.
module tb_keypad_scanner;
    localparam int DW = 4;
    localparam int DB = 2;
    localparam int FD = 4;
    localparam int PER_COL = DW + 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] row;
    logic [4:0] col;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_release;
    logic       key_ready;
    logic       overflow;
    logic       clear_ovf;
    logic       any_key;

    always #5 clk = ~clk;

    keypad_scanner #(
        .DWELL      (DW),
        .DEBOUNCE   (DB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_release (key_release),
        .key_ready   (key_ready),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf),
        .any_key     (any_key)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         mn;          // edges since scan start, -1 when idle
    logic [3:0] mrowq;
    int         mst  [20];
    int         mcnt [20];
    logic [5:0] mq [$];      // {release, code}
    logic       movf;
    logic       many;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] col_exp();
        if (mn < 0) return 5'd0;
        return 5'(1 << (4 - ((mn / PER_COL) % 5)));
    endfunction

    task automatic model_reset();
        mn = -1;
        mrowq = '0;
        for (int i = 0; i < 20; i++) begin
            mst[i]  = 0;
            mcnt[i] = 0;
        end
        mq.delete();
        movf = 1'b0;
        many = 1'b0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit         push;
        bit         full;
        bit         popped;
        bit         drop;
        logic       old_any;
        logic [5:0] ev;
        int         e, c, k, s;
        push = 0;
        drop = 0;
        ev = '0;
        old_any = 1'b0;
        for (int i = 0; i < 20; i++) if (mst[i] != 0) old_any = 1'b1;
        full   = (mq.size() == FD);
        popped = key_ready && (mq.size() > 0);
        if (!enable) begin
            mn = -1;
        end else begin
            mn = (mn < 0) ? 0 : mn + 1;
            if (mn % PER_COL == DW) mrowq = row;
            if (mn >= DW + 1 && ((mn - DW - 1) % PER_COL) < 4) begin
                e = (mn - DW - 1) % PER_COL;
                c = 4 - (((mn - DW - 1) / PER_COL) % 5);
                if (c == 0) k = 15 + e;
                else        k = 4 * (4 - c) + e;
                if (!(c == 0 && (e == 0 || e == 3))) begin
                    s = int'(mrowq[e]);
                    if (s == mst[k]) begin
                        mcnt[k] = 0;
                    end else if (mcnt[k] + 1 == DB) begin
                        mst[k]  = s;
                        mcnt[k] = 0;
                        push    = 1;
                        ev      = {(s == 0), 5'(k)};
                    end else begin
                        mcnt[k]++;
                    end
                end
            end
        end
        if (popped) void'(mq.pop_front());
        if (push) begin
            if (!full || popped) mq.push_back(ev);
            else                 drop = 1;
        end
        if (drop)           movf = 1'b1;
        else if (clear_ovf) movf = 1'b0;
        many = old_any;
    endtask

    task automatic compare_all();
        logic [5:0] head;
        head = (mq.size() > 0) ? mq[0] : 6'd0;
        chk("col",         col,         col_exp());
        chk("key_valid",   key_valid,   (mq.size() > 0));
        chk("key_code",    key_code,    head[4:0]);
        chk("key_release", key_release, head[5]);
        chk("overflow",    overflow,    movf);
        chk("any_key",     any_key,     many);
    endtask

    // Called at a falling edge: check, drive, model the next rising edge.
    task automatic step(input logic [3:0] r, input logic en, input logic rdy, input logic clr);
        compare_all();
        row       = r;
        enable    = en;
        key_ready = rdy;
        clear_ovf = clr;
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b1;
        enable    = 1'b0;
        row       = '0;
        key_ready = 1'b0;
        clear_ovf = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_col",       col,         0);
        chk("rst_key_valid", key_valid,   0);
        chk("rst_key_code",  key_code,    0);
        chk("rst_release",   key_release, 0);
        chk("rst_overflow",  overflow,    0);
        chk("rst_any_key",   any_key,     0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle scan, no keys
        for (int i = 0; i < 80; i++) step(4'b0000, 1'b1, 1'b1, 1'b0);
        chk("idle_no_event", key_valid, 0);

        // Key 5 (column 3, row 1) held for two scans, then released
        for (int i = 0; i < 80; i++) step((col_exp() == 5'b01000) ? 4'b0010 : 4'b0000, 1'b1, 1'b1, 1'b0);
        chk("any_key_pressed", any_key, 1);
        for (int i = 0; i < 80; i++) step(4'b0000, 1'b1, 1'b1, 1'b0);
        chk("any_key_released", any_key, 0);

        // One-scan glitch must not flip key 5
        for (int i = 0; i < 40; i++) step((col_exp() == 5'b01000) ? 4'b0010 : 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(4'b0000, 1'b1, 1'b1, 1'b0);
        chk("glitch_any_key", any_key, 0);

        // Column 0 with all rows asserted: only RUN and MEM
        for (int i = 0; i < 80; i++) step((col_exp() == 5'b00001) ? 4'b1111 : 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 80; i++) step(4'b0000, 1'b1, 1'b1, 1'b0);

        // Overflow: 18 presses with no consumer
        for (int i = 0; i < 80; i++) step(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("ovf_set",   overflow,  1);
        chk("ovf_valid", key_valid, 1);
        for (int i = 0; i < 80; i++) step(4'b0000, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        chk("ovf_cleared", overflow, 0);
        for (int i = 0; i < 10; i++) step(4'b0000, 1'b1, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            step(4'($urandom), 1'(($urandom % 64) != 0), 1'($urandom_range(0, 1)), 1'(($urandom % 32) == 0));

        // Reset in the middle of EMIT with events queued
        for (int i = 0; i < 60; i++) step(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16 && (mn < 0 || (mn % PER_COL) != DW + 2); i++) step(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_emit", ((mn % PER_COL) == DW + 2) && key_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_col",   col,       0);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_ovf",   overflow,  0);
        chk("mid_rst_any",   any_key,   0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        chk("restart_col", col, 5'b10000);
        for (int i = 0; i < 45; i++) step(4'b0000, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DWELL, default 1000: clk cycles each column is driven before its rows are sampled; legal range 1..65535.
REQ-002 Parameter DEBOUNCE, default 3: number of consecutive differing samples needed to flip a key state; legal range 1..3.
REQ-003 Parameter FIFO_DEPTH, default 4: key-event FIFO depth; must be a power of 2, at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  scan enable.
REQ-007 row  in  4  keypad row sense, active high.
REQ-008 col  out  5  one-hot column strobe, active high; 0 when not scanning.
REQ-009 key_valid  out  1  FIFO head holds an event.
REQ-010 key_code  out  5  head key index, 0..19 (16=RUN, 17=MEM).
REQ-011 key_release  out  1  head event is a release (1) or a press (0).
REQ-012 key_ready  in  1  consumer pops the head when key_valid&key_ready.
REQ-013 overflow  out  1  sticky flag: an event was dropped.
REQ-014 clear_ovf  in  1  clears overflow.
REQ-015 any_key  out  1  OR of all 20 debounced key states.

Function
REQ-016 FSM states: IDLE, DWELL, EMIT; IDLE->DWELL on enable=1, with column index c=4.
REQ-017 DWELL: col=1<<c; the dwell counter runs 0..DWELL-1; on count DWELL-1, row is captured into row_q and the FSM goes to EMIT with e=0.
REQ-018 EMIT: col is held at 1<<c; one key is processed per cycle, e=0..3; after e=3 the FSM enters DWELL with c=c-1, wrapping 0->4.
REQ-019 Each column takes DWELL+4 cycles; a full scan takes 5*(DWELL+4) cycles; scan order is c=4,3,2,1,0.
REQ-020 Key index k = 4*(4-c)+e; for c=0 only e=1 (k=16) and e=2 (k=17) are processed; e=0 and e=3 are ignored.
REQ-021 Debounce, with s=row_q[e] and st=stable[k]: if s==st then cnt[k]=0; else if cnt[k]+1==DEBOUNCE then stable[k]=s, cnt[k]=0 and an event {release=~s, code=k} is pushed; otherwise cnt[k]++.
REQ-022 Events are pushed in ascending k order within a column, at most one per cycle.
REQ-023 FIFO: key_valid = not empty; key_code and key_release reflect the head; a push becomes visible on the next cycle.
REQ-024 Push while full with no pop in the same cycle: the event is dropped and overflow=1; stable[k] still updates.
REQ-025 Push and pop in the same cycle while full: both take effect and no overflow is raised.
REQ-026 Push and pop in the same cycle while empty: the push is stored and the pop is ignored.
REQ-027 When clear_ovf=1 and an overflow is raised in the same cycle, overflow stays 1.
REQ-028 enable=0 in any state: the FSM goes to IDLE and col=0 on the next cycle; the dwell counter, c and e are cleared; stable, cnt and the FIFO are retained.
REQ-029 any_key updates in the cycle after stable changes.

Reset
REQ-030 On reset_n=0, asynchronously: FSM=IDLE, col=0, c=4, e=0, dwell counter=0, stable=0, cnt=0, FIFO empty, key_valid=0, key_code=0, key_release=0, overflow=0, any_key=0.
REQ-031 Reset during DWELL or EMIT aborts the scan, discards any in-flight event, and discards FIFO contents.

Structure
REQ-032 Package lcds_pkg holds: the key index constants (KEY_RUN=16, KEY_MEM=17, NUM_KEYS=20), the key_event_t struct {release, code[4:0]}, and the scan_state_t enum.
REQ-033 The FIFO is a sub-module, keypad_event_fifo, with push/pop/full/empty and FIFO_DEPTH; scan FSM and debounce stay in keypad_scanner.

Verification (DWELL=4, DEBOUNCE=2, FIFO_DEPTH=4)
REQ-034 Reset, then enable=1 with row=0 -> col=10000 for 8 cycles, then 01000, 00100, 00010, 00001; repeats every 40 cycles; no events.
REQ-035 row[1]=1 whenever col=01000, held for 2 scans -> one event code=5 release=0; then row=0 for 2 scans -> code=5 release=1; any_key goes 1 then 0.
REQ-036 row[1]=1 during col=01000 for 1 scan only -> no event, stable[5]=0.
REQ-037 col=00001 with row=1111 for 2 scans -> exactly two events, codes 16 then 17 in consecutive cycles; rows 0 and 3 are ignored.
REQ-038 key_ready=0 and 6 debounced transitions -> 4 stored, overflow=1; pop with a simultaneous push while full -> no drop; clear_ovf -> overflow=0.
REQ-039 reset_n=0 in mid-EMIT with 2 events queued -> col=0, key_valid=0 immediately; after release of reset and enable=1, the scan restarts at col=10000.
